// File: rtl/icache_refill.sv
// Fetch-side icache controller: one outstanding IFU fetch, direct-mapped lookup,
// single-word refill from the memory bus on a miss, hit/miss performance counters.
module icache_refill #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  // IFU side
  input  logic             ifu_reqValid,
  output logic             ifu_reqReady,
  input  logic [29:0]      ifu_addr,
  output logic             ifu_respValid,
  output logic [31:0]      ifu_rdata,
  output logic             ifu_respErr,
  // icache side
  output logic             cache_reqValid,
  output logic [29:0]      cache_addr,
  input  logic             cache_is_hit,
  input  logic [31:0]      cache_rdata,
  output logic             cache_wen,
  output logic [31:0]      cache_wdata,
  // memory bus side
  output logic             mem_reqValid,
  input  logic             mem_reqReady,
  output logic [31:0]      mem_addr,
  input  logic             mem_respValid,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_respErr,
  // performance counters
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int unsigned AW = 30;
  localparam int unsigned DW = 32;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOOKUP   = 3'd1,
    MEM_REQ  = 3'd2,
    MEM_WAIT = 3'd3,
    FILL     = 3'd4,
    RESP     = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    data_q, data_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

  // Strobes are registered copies of the next-state decode, so they line up with state_q.
  logic             req_ready_q, req_ready_d;
  logic             resp_valid_q, resp_valid_d;
  logic             resp_err_q, resp_err_d;
  logic             cache_req_q, cache_req_d;
  logic             cache_wen_q, cache_wen_d;
  logic             mem_req_q, mem_req_d;

  // Next-state, datapath and strobe decode.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    data_d       = data_q;
    err_d        = err_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (ifu_reqValid) begin
          addr_d  = ifu_addr;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (cache_is_hit) begin
          data_d    = cache_rdata;
          err_d     = 1'b0;
          hit_cnt_d = hit_cnt_q + CNT_W'(1);
          state_d   = RESP;
        end else begin
          miss_cnt_d = miss_cnt_q + CNT_W'(1);
          state_d    = MEM_REQ;
        end
      end
      MEM_REQ: begin
        if (mem_reqReady) begin
          state_d = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (mem_respValid) begin
          if (mem_respErr) begin
            // Error: skip the fill so the line is never written with bad data.
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            data_d  = mem_rdata;
            err_d   = 1'b0;
            state_d = FILL;
          end
        end
      end
      FILL:    state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    req_ready_d  = (state_d == IDLE);
    resp_valid_d = (state_d == RESP);
    resp_err_d   = (state_d == RESP) && err_d;
    cache_req_d  = (state_d == LOOKUP);
    cache_wen_d  = (state_d == FILL);
    mem_req_d    = (state_d == MEM_REQ);
  end

  // State, datapath and strobe registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      data_q       <= '0;
      err_q        <= 1'b0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      cache_req_q  <= 1'b0;
      cache_wen_q  <= 1'b0;
      mem_req_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      err_q        <= err_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      cache_req_q  <= cache_req_d;
      cache_wen_q  <= cache_wen_d;
      mem_req_q    <= mem_req_d;
    end
  end

  assign ifu_reqReady   = req_ready_q;
  assign ifu_respValid  = resp_valid_q;
  assign ifu_respErr    = resp_err_q;
  assign ifu_rdata      = data_q;
  assign cache_reqValid = cache_req_q;
  assign cache_addr     = addr_q;
  assign cache_wen      = cache_wen_q;
  assign cache_wdata    = data_q;
  assign mem_reqValid   = mem_req_q;
  assign mem_addr       = {addr_q, 2'b00};
  assign hit_cnt        = hit_cnt_q;
  assign miss_cnt       = miss_cnt_q;

endmodule

// File: tb/tb_icache_refill.sv
// Bench for icache_refill: icache and memory models, vector table, response scoreboard.
module tb_icache_refill;

  localparam int unsigned CW = 3;   // small counters so wrap-around is reachable

  logic          clock;
  logic          reset;
  logic          ifu_reqValid;
  logic          ifu_reqReady;
  logic [29:0]   ifu_addr;
  logic          ifu_respValid;
  logic [31:0]   ifu_rdata;
  logic          ifu_respErr;
  logic          cache_reqValid;
  logic [29:0]   cache_addr;
  logic          cache_is_hit;
  logic [31:0]   cache_rdata;
  logic          cache_wen;
  logic [31:0]   cache_wdata;
  logic          mem_reqValid;
  logic          mem_reqReady;
  logic [31:0]   mem_addr;
  logic          mem_respValid;
  logic [31:0]   mem_rdata;
  logic          mem_respErr;
  logic [CW-1:0] hit_cnt;
  logic [CW-1:0] miss_cnt;

  icache_refill #(.CNT_W(CW)) dut (
    .clock          (clock),
    .reset          (reset),
    .ifu_reqValid   (ifu_reqValid),
    .ifu_reqReady   (ifu_reqReady),
    .ifu_addr       (ifu_addr),
    .ifu_respValid  (ifu_respValid),
    .ifu_rdata      (ifu_rdata),
    .ifu_respErr    (ifu_respErr),
    .cache_reqValid (cache_reqValid),
    .cache_addr     (cache_addr),
    .cache_is_hit   (cache_is_hit),
    .cache_rdata    (cache_rdata),
    .cache_wen      (cache_wen),
    .cache_wdata    (cache_wdata),
    .mem_reqValid   (mem_reqValid),
    .mem_reqReady   (mem_reqReady),
    .mem_addr       (mem_addr),
    .mem_respValid  (mem_respValid),
    .mem_rdata      (mem_rdata),
    .mem_respErr    (mem_respErr),
    .hit_cnt        (hit_cnt),
    .miss_cnt       (miss_cnt)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Direct-mapped icache model: 16 lines, index = addr[3:0], tag = addr[29:4].
  logic        cv   [16];
  logic [25:0] ctag [16];
  logic [31:0] cdat [16];

  assign cache_is_hit = cv[cache_addr[3:0]] && (ctag[cache_addr[3:0]] == cache_addr[29:4]);
  assign cache_rdata  = cdat[cache_addr[3:0]];

  // Cache contents: invalidated on reset, written by the fill strobe.
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        cv[i]   <= 1'b0;
        ctag[i] <= '0;
        cdat[i] <= '0;
      end
    end else if (cache_wen) begin
      cv[cache_addr[3:0]]   <= 1'b1;
      ctag[cache_addr[3:0]] <= cache_addr[29:4];
      cdat[cache_addr[3:0]] <= cache_wdata;
    end
  end

  typedef struct {
    logic [29:0] addr;
    logic [31:0] mdata;
    logic        merr;
    int          rd;       // MEM_REQ cycles without ready before the handshake cycle
    int          sd;       // MEM_WAIT cycles before the response cycle
    logic        exp_hit;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_lat;  // accept cycle to ifu_respValid cycle
    int          exp_hits;
    int          exp_miss;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          due;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[12];

  // Scoreboard: every response pops the oldest expectation.
  always @(negedge clock) begin
    if (!reset && ifu_respValid) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp", 64'(ifu_rdata), 64'hDEAD_0000_0000);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_data", 64'(ifu_rdata), 64'(e.data));
        chk("resp_err", 64'(ifu_respErr), 64'(e.err));
        chk("resp_cycle", 64'(cyc), 64'(e.due));
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!ifu_reqReady && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!ifu_reqReady) chk("ready_timeout", 64'(ifu_reqReady), 64'd1);
  endtask

  // Play memory for one fetch accepted at the previous posedge; return at its RESP negedge.
  task automatic serve(input vec_t v, input logic hold, input logic [29:0] next_addr);
    int  fills = 0;
    int  memreqs = 0;
    int  rcnt = 0;
    int  wcnt = 0;
    logic hs = 1'b0;
    logic done = 1'b0;
    for (int i = 0; i < 80 && !done; i++) begin
      @(negedge clock);
      if (i == 0) begin
        if (hold) ifu_addr = next_addr;
        else      ifu_reqValid = 1'b0;
      end
      mem_reqReady  = 1'b0;
      mem_respValid = 1'b0;
      mem_respErr   = 1'b0;
      mem_rdata     = $urandom;
      chk("busy_not_ready", 64'(ifu_reqReady), 64'd0);
      if (ifu_respValid) done = 1'b1;
      if (cache_wen) begin
        fills++;
        chk("fill_data", 64'(cache_wdata), 64'(v.mdata));
        chk("fill_addr", 64'(cache_addr), 64'(v.addr));
      end
      if (mem_reqValid) begin
        memreqs++;
        chk("mem_addr", 64'(mem_addr), 64'({v.addr, 2'b00}));
        if (rcnt == v.rd) begin
          mem_reqReady = 1'b1;
          hs = 1'b1;
        end else begin
          rcnt++;
        end
      end else if (hs) begin
        if (wcnt == v.sd) begin
          mem_respValid = 1'b1;
          mem_rdata     = v.mdata;
          mem_respErr   = v.merr;
          hs = 1'b0;
        end else begin
          wcnt++;
        end
      end
    end
    if (!done) chk("resp_timeout", 64'd0, 64'd1);
    chk("fill_count", 64'(fills), 64'((!v.exp_hit && !v.exp_err) ? 1 : 0));
    chk("memreq_cycles", 64'(memreqs), 64'(v.exp_hit ? 0 : v.rd + 1));
    mem_reqReady  = 1'b0;
    mem_respValid = 1'b0;
    mem_respErr   = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    wait_ready();
    ifu_reqValid = 1'b1;
    ifu_addr     = v.addr;
    e.data = v.exp_data;
    e.err  = v.exp_err;
    e.due  = cyc + v.exp_lat;
    sb.push_back(e);
    serve(v, 1'b0, '0);
    chk("hit_cnt", 64'(hit_cnt), 64'(v.exp_hits));
    chk("miss_cnt", 64'(miss_cnt), 64'(v.exp_miss));
  endtask

  initial begin
    exp_t e;
    vec_t vx;
    vec_t vy;

    //          addr           mdata          err  rd sd hit   exp_data       eerr lat hits miss
    vecs[0]  = '{30'h100,      32'h0000_0013, 1'b0, 0, 0, 1'b0, 32'h0000_0013, 1'b0, 5,  0, 1};
    vecs[1]  = '{30'h100,      32'h0000_0000, 1'b0, 0, 0, 1'b1, 32'h0000_0013, 1'b0, 2,  1, 1};
    vecs[2]  = '{30'h110,      32'h0000_0093, 1'b0, 0, 1, 1'b0, 32'h0000_0093, 1'b0, 6,  1, 2};
    vecs[3]  = '{30'h100,      32'h0000_0013, 1'b0, 1, 0, 1'b0, 32'h0000_0013, 1'b0, 6,  1, 3};
    vecs[4]  = '{30'h205,      32'hAAAA_5555, 1'b1, 4, 2, 1'b0, 32'h0000_0013, 1'b1, 10, 1, 4};
    vecs[5]  = '{30'h205,      32'h1234_5678, 1'b0, 0, 0, 1'b0, 32'h1234_5678, 1'b0, 5,  1, 5};
    vecs[6]  = '{30'h205,      32'h0000_0000, 1'b0, 0, 0, 1'b1, 32'h1234_5678, 1'b0, 2,  2, 5};
    vecs[7]  = '{30'h110,      32'h0000_0093, 1'b0, 0, 0, 1'b0, 32'h0000_0093, 1'b0, 5,  2, 6};
    vecs[8]  = '{30'h100,      32'h0000_0013, 1'b0, 2, 3, 1'b0, 32'h0000_0013, 1'b0, 10, 2, 7};
    vecs[9]  = '{30'h3FFFFFFF, 32'hCAFE_F00D, 1'b0, 0, 0, 1'b0, 32'hCAFE_F00D, 1'b0, 5,  2, 0};
    vecs[10] = '{30'h3FFFFFFF, 32'h0000_0000, 1'b0, 0, 0, 1'b1, 32'hCAFE_F00D, 1'b0, 2,  3, 0};
    vecs[11] = '{30'h100,      32'h0000_0000, 1'b0, 0, 0, 1'b1, 32'h0000_0013, 1'b0, 2,  4, 0};

    reset         = 1'b1;
    ifu_reqValid  = 1'b0;
    ifu_addr      = '0;
    mem_reqReady  = 1'b0;
    mem_respValid = 1'b0;
    mem_rdata     = '0;
    mem_respErr   = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;

    // Reset state.
    chk("rst_reqReady", 64'(ifu_reqReady), 64'd1);
    chk("rst_respValid", 64'(ifu_respValid), 64'd0);
    chk("rst_respErr", 64'(ifu_respErr), 64'd0);
    chk("rst_cache_req", 64'(cache_reqValid), 64'd0);
    chk("rst_cache_wen", 64'(cache_wen), 64'd0);
    chk("rst_mem_req", 64'(mem_reqValid), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_rdata", 64'(ifu_rdata), 64'd0);
    chk("rst_hits", 64'(hit_cnt), 64'd0);
    chk("rst_miss", 64'(miss_cnt), 64'd0);

    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    // Request held during a refill is taken only in the first IDLE cycle after RESP.
    vx = '{30'h120, 32'h0000_0077, 1'b0, 0, 0, 1'b0, 32'h0000_0077, 1'b0, 5, 4, 1};
    vy = '{30'h100, 32'h0000_0013, 1'b0, 0, 0, 1'b0, 32'h0000_0013, 1'b0, 5, 4, 2};
    wait_ready();
    ifu_reqValid = 1'b1;
    ifu_addr     = vx.addr;
    e.data = vx.exp_data; e.err = 1'b0; e.due = cyc + vx.exp_lat;
    sb.push_back(e);
    serve(vx, 1'b1, vy.addr);
    chk("busy_x_miss", 64'(miss_cnt), 64'(vx.exp_miss));
    @(negedge clock);
    chk("busy_idle_ready", 64'(ifu_reqReady), 64'd1);
    e.data = vy.exp_data; e.err = 1'b0; e.due = cyc + vy.exp_lat;
    sb.push_back(e);
    serve(vy, 1'b0, '0);
    chk("busy_hits", 64'(hit_cnt), 64'(vy.exp_hits));
    chk("busy_miss", 64'(miss_cnt), 64'(vy.exp_miss));

    // Reset taken in MEM_WAIT, then a stale memory response.
    wait_ready();
    ifu_reqValid = 1'b1;
    ifu_addr     = 30'h0C0;
    @(negedge clock);
    ifu_reqValid = 1'b0;
    for (int n = 0; n < 10 && !mem_reqValid; n++) @(negedge clock);
    chk("rst_test_memreq", 64'(mem_reqValid), 64'd1);
    mem_reqReady = 1'b1;
    @(negedge clock);
    mem_reqReady = 1'b0;
    chk("rst_test_in_wait", 64'(mem_reqValid), 64'd0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    mem_respValid = 1'b1;
    mem_rdata     = 32'hDEAD_BEEF;
    mem_respErr   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("stale_no_wen", 64'(cache_wen), 64'd0);
      chk("stale_no_resp", 64'(ifu_respValid), 64'd0);
      chk("stale_ready", 64'(ifu_reqReady), 64'd1);
      chk("stale_no_memreq", 64'(mem_reqValid), 64'd0);
      chk("stale_hits", 64'(hit_cnt), 64'd0);
      chk("stale_miss", 64'(miss_cnt), 64'd0);
      @(negedge clock);
    end
    mem_respValid = 1'b0;

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache_refill.md
Name: icache_refill

Overview:
Fetch-side controller that owns the instruction cache's lookup and fill ports. It accepts one fetch request at a time from the IFU and looks the word up in the direct-mapped icache (16 lines, one 32-bit word per line). On a miss it issues a single-word read to the memory bus and writes the returned word into the cache, then returns the word to the IFU. It also keeps hit and miss counters for performance reporting.

Parameters:
CNT_W, 32, width of the hit and miss counters; counters wrap modulo 2^CNT_W.

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
ifu_reqValid  input  1  fetch request
ifu_reqReady  output  1  controller can accept a request; high only in IDLE
ifu_addr  input  30  word address [31:2]
ifu_respValid  output  1  one-cycle pulse; response data is valid
ifu_rdata  output  32  fetched instruction word
ifu_respErr  output  1  bus error on refill; qualified by ifu_respValid
cache_reqValid  output  1  lookup strobe to icache
cache_addr  output  30  lookup/fill word address
cache_is_hit  input  1  combinational hit from icache
cache_rdata  input  32  combinational line data from icache
cache_wen  output  1  fill strobe
cache_wdata  output  32  fill data
mem_reqValid  output  1  memory read request
mem_reqReady  input  1  memory accepts request
mem_addr  output  32  byte address, equal to {addr_q, 2'b00}
mem_respValid  input  1  memory read data valid
mem_rdata  input  32  memory read data
mem_respErr  input  1  memory error; qualified by mem_respValid
hit_cnt  output  CNT_W  number of lookups that hit
miss_cnt  output  CNT_W  number of lookups that missed

Behaviour:
- Clock and reset: single clock `clock`. `reset` is synchronous and active-high. All state is updated on the posedge of `clock` only.
- Reset values:
  - State is IDLE.
  - addr_q, data_q, hit_cnt and miss_cnt are 0.
  - ifu_respValid, ifu_respErr, cache_reqValid, cache_wen and mem_reqValid are 0.
  - ifu_reqReady is 1.
- Registered state: addr_q[31:2], data_q[31:0], err_q, hit_cnt, miss_cnt.
- State machine: IDLE, LOOKUP, MEM_REQ, MEM_WAIT, FILL, RESP.
  - IDLE: ifu_reqReady=1. When ifu_reqValid is high, latch addr_q<=ifu_addr and go to LOOKUP.
  - LOOKUP: cache_reqValid=1 and cache_addr=addr_q.
    - cache_is_hit=1: data_q<=cache_rdata, err_q<=0, hit_cnt++, go to RESP.
    - Otherwise: miss_cnt++, go to MEM_REQ.
  - MEM_REQ: mem_reqValid=1 and mem_addr={addr_q,2'b00}. Hold both stable until mem_reqReady. When mem_reqReady is high, go to MEM_WAIT; mem_reqValid drops in that same transition.
  - MEM_WAIT: wait for mem_respValid.
    - mem_respErr=1: err_q<=1 and go to RESP. The cache is not filled.
    - Otherwise: data_q<=mem_rdata, err_q<=0, go to FILL.
  - FILL: cache_wen=1, cache_addr=addr_q, cache_wdata=data_q for exactly one cycle, then go to RESP.
  - RESP: ifu_respValid=1, ifu_rdata=data_q, ifu_respErr=err_q for one cycle, then go to IDLE.
- Output defaults: cache_addr=addr_q in every state. cache_reqValid, cache_wen and mem_reqValid are 0 outside their states. ifu_rdata holds data_q at all times.
- Latency, counted from the accept cycle T (ifu_reqValid && ifu_reqReady):
  - Hit: ifu_respValid at T+2.
  - Miss with mem_reqReady in T+2 and mem_respValid in cycle R: fill at R+1, ifu_respValid at R+2.
  - Minimum miss latency is 5 cycles (R=T+3).
- Boundary conditions:
  - Only one request is outstanding at a time. ifu_reqValid outside IDLE is ignored and not queued.
  - mem_respValid in any state other than MEM_WAIT is ignored. This covers a stale response after a reset taken during MEM_WAIT.
  - A request accepted in the same cycle that RESP ends is impossible: ifu_reqReady is 0 in RESP, so back-to-back accepts are 3 cycles apart on hits.
  - Counter overflow wraps to 0. No saturation.
  - Reset in any state returns to IDLE next cycle with all strobes low. No partial fill occurs, because cache_wen is asserted only in FILL.
  - An error response is returned to the IFU with ifu_rdata=data_q, which holds a stale value. A later fetch to the same address misses again.

Test Plan:
1. Cold miss: reset, then ifu_addr=0x0000_0400>>2. Memory is ready immediately and responds 0x00000013 two cycles later. Expect mem_addr=0x400, one cache_wen pulse with wdata 0x13, ifu_respValid at T+5 with ifu_rdata=0x13, miss_cnt=1.
2. Hit after fill: repeat the fetch at 0x400. Expect no mem_reqValid, ifu_respValid at T+2 with rdata=0x13, hit_cnt=1.
3. Conflict: fetch 0x440, which has the same index as 0x400 and a different tag. Expect a miss and a refill. A following fetch of 0x400 misses again, giving miss_cnt=3.
4. Backpressure and error: hold mem_reqReady=0 for 4 cycles, then respond with mem_respErr=1. Expect mem_addr held stable, no cache_wen, ifu_respValid with ifu_respErr=1. A refetch of the same address misses.
5. Reset mid-refill: assert reset in MEM_WAIT, then drive mem_respValid=1 with 0xDEADBEEF after reset. Expect no cache_wen and no ifu_respValid, counters=0, ifu_reqReady=1.
6. Request during busy: hold ifu_reqValid with a new address while in MEM_WAIT. Expect it to be accepted only in the first IDLE cycle after RESP.
